// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-wide load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} lsu_state_t;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LSU_ADDR_W = 8;
    localparam int unsigned LSU_DATA_W = 16;

endpackage

// File: rtl/load_store_unit.sv
// Sequences 8/16-bit little-endian loads/stores as one or two byte accesses on the data memory.
// Optional: define LSU_MISALIGN_CHECK_EN to reject odd-address word accesses with resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_word,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [7:0]        mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [7:0]        mem_read_data
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
`ifdef LSU_MISALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            word_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            word_q   <= word_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        word_d   = word_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
`ifdef LSU_MISALIGN_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    word_d   = req_word;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    state_d  = LO;
`ifdef LSU_MISALIGN_CHECK_EN
                    err_d    = req_word & req_addr[0];
                    // Misaligned word: skip the memory phases entirely.
                    if (req_word && req_addr[0]) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            LO: begin
                if (!we_q) begin
                    lo_d = mem_read_data;
                end
                state_d = word_q ? HI : DONE;
            end
            HI: begin
                if (!we_q) begin
                    hi_d = mem_read_data;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_q == IDLE) && !rst;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_err        = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        case (state_q)
            LO: begin
                mem_access_addr = addr_q;
                if (we_q) begin
                    mem_write_en   = 1'b1;
                    mem_write_data = wdata_q[BYTE_W-1:0];
                end else begin
                    mem_read = 1'b1;
                end
            end
            HI: begin
                // Address wraps modulo 2^ADDR_W.
                mem_access_addr = addr_q + ADDR_W'(1);
                if (we_q) begin
                    mem_write_en   = 1'b1;
                    mem_write_data = wdata_q[DATA_W-1 -: BYTE_W];
                end else begin
                    mem_read = 1'b1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (!we_q) begin
                    resp_rdata = word_q ? {hi_q, lo_q}
                                        : {{BYTE_W{signed_q & lo_q[BYTE_W-1]}}, lo_q};
                end
`ifdef LSU_MISALIGN_CHECK_EN
                resp_err = err_q;
                if (err_q) begin
                    resp_rdata = '0;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule
